// File: rtl/param_reg_file_pkg.sv
// Shared definitions for the parametrised register file: the function-bus
// encodings and the select-width helper.
package param_reg_file_pkg;

   localparam logic [2:0] FS_DEC  = 3'b000;
   localparam logic [2:0] FS_INC  = 3'b001;
   localparam logic [2:0] FS_LOAD = 3'b010;
   localparam logic [2:0] FS_CLR  = 3'b011;
   localparam logic [2:0] FS_LDL  = 3'b100;
   localparam logic [2:0] FS_LDH  = 3'b101;
   localparam logic [2:0] FS_SHL  = 3'b110;
   localparam logic [2:0] FS_HOLD = 3'b111;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/param_reg_file_cell.sv
// One register of the file plus its sticky wrap flag; performs FunSel when En
// is high.
module param_reg_cell
   import param_reg_file_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             En,
   input  logic [2:0]       FunSel,
   input  logic [WIDTH-1:0] I,
   output logic [WIDTH-1:0] Q,
   output logic             Wrap
);

   localparam int HALF = WIDTH / 2;

   logic [WIDTH-1:0] q_nxt;
   logic             wrap_nxt;

   always_comb begin
      q_nxt    = Q;
      wrap_nxt = Wrap;
      case (FunSel)
         FS_DEC: begin
            q_nxt = Q - WIDTH'(1);
            if (Q == '0) wrap_nxt = 1'b1;
         end
         FS_INC: begin
            q_nxt = Q + WIDTH'(1);
            if (&Q) wrap_nxt = 1'b1;
         end
         FS_LOAD: begin
            q_nxt    = I;
            wrap_nxt = 1'b0;
         end
         FS_CLR: begin
            q_nxt    = '0;
            wrap_nxt = 1'b0;
         end
         FS_LDL: begin
            q_nxt[HALF-1:0] = I[HALF-1:0];
            wrap_nxt        = 1'b0;
         end
         // the high half is loaded from the low half of the bus
         FS_LDH: begin
            q_nxt[WIDTH-1:HALF] = I[HALF-1:0];
            wrap_nxt            = 1'b0;
         end
         FS_SHL: begin
            q_nxt = {Q[WIDTH-2:0], 1'b0};
            if (Q[WIDTH-1]) wrap_nxt = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         Q    <= '0;
         Wrap <= 1'b0;
      end else if (En) begin
         Q    <= q_nxt;
         Wrap <= wrap_nxt;
      end
   end

endmodule

// File: rtl/param_reg_file.sv
// NREGS x WIDTH register file: shared function bus with active-low per-register
// select, two combinational read ports and a zero detect on port A.
module param_reg_file
   import param_reg_file_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int NREGS = 4,
   localparam int SELW  = (clog2(NREGS) > 1) ? clog2(NREGS) : 1
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [2:0]       FunSel,
   input  logic [NREGS-1:0] RegSel,
   input  logic [WIDTH-1:0] I,
   input  logic [SELW-1:0]  OutASel,
   input  logic [SELW-1:0]  OutBSel,
   output logic [WIDTH-1:0] OutA,
   output logic [WIDTH-1:0] OutB,
   output logic             ZeroA,
   output logic [NREGS-1:0] WrapFlags
);

   logic [WIDTH-1:0] regs [NREGS];

   for (genvar k = 0; k < NREGS; k++) begin : g_cell
      param_reg_cell #(
         .WIDTH (WIDTH)
      ) u_cell (
         .Clock  (Clock),
         .Reset  (Reset),
         .En     (~RegSel[k]),
         .FunSel (FunSel),
         .I      (I),
         .Q      (regs[k]),
         .Wrap   (WrapFlags[k])
      );
   end

   // Selects past the last register read as zero when NREGS is not a power of two.
   always_comb begin
      OutA = '0;
      OutB = '0;
      if (int'(OutASel) < NREGS) OutA = regs[OutASel];
      if (int'(OutBSel) < NREGS) OutB = regs[OutBSel];
   end

   assign ZeroA = (OutA == '0);

endmodule

// File: tb/tb_param_reg_file.sv
// Directed bench for param_reg_file: the driver queues hand-computed read
// expectations, a monitor checks them on the falling clock edge.
module tb_param_reg_file;
   import param_reg_file_pkg::*;

   logic       Clock;
   logic       Reset;
   logic [2:0] FunSel;
   logic [3:0] RegSel;
   logic [7:0] I;
   logic [1:0] OutASel, OutBSel;
   logic [7:0] OutA, OutB;
   logic       ZeroA;
   logic [3:0] WrapFlags;

   logic [2:0] FunSel3;
   logic [2:0] RegSel3;
   logic [7:0] I3;
   logic [1:0] OutASel3, OutBSel3;
   logic [7:0] OutA3, OutB3;
   logic       ZeroA3;
   logic [2:0] WrapFlags3;

   typedef struct {
      int         kind;
      string      name;
      logic [7:0] ea;
      logic [7:0] eb;
      logic       ez;
      logic [3:0] ewf;
   } exp_t;

   exp_t sb_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   param_reg_file #(.WIDTH(8), .NREGS(4)) dut (
      .Clock(Clock), .Reset(Reset), .FunSel(FunSel), .RegSel(RegSel), .I(I),
      .OutASel(OutASel), .OutBSel(OutBSel), .OutA(OutA), .OutB(OutB),
      .ZeroA(ZeroA), .WrapFlags(WrapFlags)
   );

   param_reg_file #(.WIDTH(8), .NREGS(3)) dut3 (
      .Clock(Clock), .Reset(Reset), .FunSel(FunSel3), .RegSel(RegSel3), .I(I3),
      .OutASel(OutASel3), .OutBSel(OutBSel3), .OutA(OutA3), .OutB(OutB3),
      .ZeroA(ZeroA3), .WrapFlags(WrapFlags3)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", nm, act, exp);
      end
   endtask

   // Monitor: every queued expectation is checked against the live outputs.
   initial begin
      forever begin
         @(negedge Clock);
         while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            if (e.kind == 0) begin
               chk({e.name, ".OutA"}, OutA, e.ea);
               chk({e.name, ".OutB"}, OutB, e.eb);
               chk({e.name, ".ZeroA"}, {7'd0, ZeroA}, {7'd0, e.ez});
               chk({e.name, ".WrapFlags"}, {4'd0, WrapFlags}, {4'd0, e.ewf});
            end else begin
               chk({e.name, ".OutA"}, OutA3, e.ea);
               chk({e.name, ".OutB"}, OutB3, e.eb);
               chk({e.name, ".ZeroA"}, {7'd0, ZeroA3}, {7'd0, e.ez});
               chk({e.name, ".WrapFlags"}, {5'd0, WrapFlags3}, {4'd0, e.ewf});
            end
         end
      end
   end

   task automatic push(input int kind, input string nm, input logic [7:0] ea,
                       input logic [7:0] eb, input logic ez, input logic [3:0] ewf);
      exp_t e;
      e.kind = kind; e.name = nm; e.ea = ea; e.eb = eb; e.ez = ez; e.ewf = ewf;
      sb_q.push_back(e);
   endtask

   // Applies an op for the next edge and expects the reads of the current state.
   task automatic step(input logic [2:0] fs, input logic [3:0] rs, input logic [7:0] iv,
                       input logic [1:0] as, input logic [1:0] bs,
                       input logic [7:0] ea, input logic [7:0] eb, input logic ez,
                       input logic [3:0] ewf, input string nm);
      FunSel = fs; RegSel = rs; I = iv; OutASel = as; OutBSel = bs;
      push(0, nm, ea, eb, ez, ewf);
      @(posedge Clock); #1;
   endtask

   task automatic step3(input logic [2:0] fs, input logic [2:0] rs, input logic [7:0] iv,
                        input logic [1:0] as, input logic [1:0] bs,
                        input logic [7:0] ea, input logic [7:0] eb, input logic ez,
                        input logic [2:0] ewf, input string nm);
      FunSel3 = fs; RegSel3 = rs; I3 = iv; OutASel3 = as; OutBSel3 = bs;
      push(1, nm, ea, eb, ez, {1'b0, ewf});
      @(posedge Clock); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int budget;
      Reset = 1'b1;
      FunSel = FS_HOLD; RegSel = 4'hF; I = 8'h00; OutASel = 2'd0; OutBSel = 2'd1;
      FunSel3 = FS_HOLD; RegSel3 = 3'b111; I3 = 8'h00; OutASel3 = 2'd0; OutBSel3 = 2'd0;
      repeat (2) @(posedge Clock);
      #1;
      step(FS_HOLD, 4'hF, 8'h00, 2'd0, 2'd1, 8'h00, 8'h00, 1'b1, 4'h0, "rst_init");
      Reset = 1'b0;

      step(FS_LOAD, 4'b1110, 8'h5A, 2'd0, 2'd1, 8'h00, 8'h00, 1'b1, 4'h0, "pre_load");
      step(FS_LOAD, 4'b1101, 8'hC3, 2'd0, 2'd1, 8'h5A, 8'h00, 1'b0, 4'h0, "load_r0");
      step(FS_HOLD, 4'hF,    8'h00, 2'd0, 2'd1, 8'h5A, 8'hC3, 1'b0, 4'h0, "load_read");
      step(FS_HOLD, 4'hF,    8'h00, 2'd2, 2'd3, 8'h00, 8'h00, 1'b1, 4'h0, "r23_zero");

      step(FS_LOAD, 4'b1011, 8'hFF, 2'd2, 2'd2, 8'h00, 8'h00, 1'b1, 4'h0, "pre_ff");
      step(FS_INC,  4'b1011, 8'h00, 2'd2, 2'd0, 8'hFF, 8'h5A, 1'b0, 4'h0, "r2_ff");
      step(FS_DEC,  4'b1011, 8'h00, 2'd2, 2'd2, 8'h00, 8'h00, 1'b1, 4'h4, "inc_wrap");
      step(FS_LOAD, 4'b1011, 8'h10, 2'd2, 2'd1, 8'hFF, 8'hC3, 1'b0, 4'h4, "dec_wrap");
      step(FS_HOLD, 4'hF,    8'h00, 2'd2, 2'd2, 8'h10, 8'h10, 1'b0, 4'h0, "load_clr_flag");

      step(FS_LDH,  4'b0111, 8'hFB, 2'd3, 2'd3, 8'h00, 8'h00, 1'b1, 4'h0, "pre_half");
      step(FS_LDL,  4'b0111, 8'hE7, 2'd3, 2'd0, 8'hB0, 8'h5A, 1'b0, 4'h0, "ldh");
      step(FS_HOLD, 4'hF,    8'h00, 2'd3, 2'd3, 8'hB7, 8'hB7, 1'b0, 4'h0, "ldl");

      step(FS_LOAD, 4'b1110, 8'h01, 2'd0, 2'd1, 8'h5A, 8'hC3, 1'b0, 4'h0, "pre_multi");
      step(FS_LOAD, 4'b1101, 8'h80, 2'd0, 2'd1, 8'h01, 8'hC3, 1'b0, 4'h0, "r0_01");
      step(FS_SHL,  4'b1100, 8'h00, 2'd0, 2'd1, 8'h01, 8'h80, 1'b0, 4'h0, "shl_no_bypass");
      step(FS_CLR,  4'b1110, 8'h00, 2'd1, 2'd0, 8'h00, 8'h02, 1'b1, 4'h2, "shl_multi");
      step(FS_DEC,  4'b1110, 8'h00, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1, 4'h2, "clr_r0");
      step(FS_INC,  4'b0111, 8'h00, 2'd0, 2'd3, 8'hFF, 8'hB7, 1'b0, 4'h3, "dec_wrap_r0");
      step(FS_SHL,  4'b0111, 8'h00, 2'd3, 2'd0, 8'hB8, 8'hFF, 1'b0, 4'h3, "inc_r3");
      step(FS_LOAD, 4'hF,    8'h55, 2'd3, 2'd1, 8'h70, 8'h00, 1'b0, 4'hB, "shl_wrap_r3");
      step(FS_HOLD, 4'hF,    8'h00, 2'd3, 2'd2, 8'h70, 8'h10, 1'b0, 4'hB, "no_select");

      FunSel = FS_INC; RegSel = 4'h0; OutASel = 2'd0; OutBSel = 2'd3;
      Reset = 1'b1;
      push(0, "rst_async", 8'h00, 8'h00, 1'b1, 4'h0);
      @(posedge Clock); #1;
      Reset = 1'b0;
      push(0, "rst_clean", 8'h00, 8'h00, 1'b1, 4'h0);
      @(posedge Clock); #1;
      step(FS_INC,  4'h0,    8'h00, 2'd0, 2'd3, 8'h01, 8'h01, 1'b0, 4'h0, "inc_after_rst");
      @(negedge Clock); #4;
      Reset = 1'b1;
      @(posedge Clock); #1;
      Reset = 1'b0;
      step(FS_HOLD, 4'hF,    8'h00, 2'd0, 2'd2, 8'h00, 8'h00, 1'b1, 4'h0, "rst_during_inc");

      step3(FS_LOAD, 3'b011, 8'h33, 2'd2, 2'd0, 8'h00, 8'h00, 1'b1, 3'h0, "n3_pre");
      step3(FS_INC,  3'b110, 8'h00, 2'd2, 2'd0, 8'h33, 8'h00, 1'b0, 3'h0, "n3_load");
      step3(FS_HOLD, 3'b111, 8'h00, 2'd3, 2'd0, 8'h00, 8'h01, 1'b1, 3'h0, "n3_oor_a");
      step3(FS_HOLD, 3'b111, 8'h00, 2'd2, 2'd3, 8'h33, 8'h00, 1'b0, 3'h0, "n3_oor_b");

      budget = 10;
      while (sb_q.size() > 0 && budget > 0) begin
         @(posedge Clock);
         budget--;
      end
      if (sb_q.size() > 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain: got %0d pending expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/param_reg_file.md
Name: param_reg_file

Overview:
- Parametrised, clocked general-purpose register file.
- Provides NREGS registers of WIDTH bits and two independent combinational read ports.
- One shared write/function bus with per-register active-low select.
- Replaces fixed 4x8 register banks in the datapath; also usable as the address-register bank (NREGS=3) or instruction register (NREGS=1, WIDTH=16, half loads).

Parameters:
- WIDTH, 8, bits per register; must be even (half-load ops).
- NREGS, 4, number of registers, 1..16.
- SELW, derived localparam = max(1, clog2(NREGS)), read-select width; not user-overridable.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- FunSel  in  3  operation applied to every selected register (encodings below).
- RegSel  in  NREGS  active-low per-register enable; bit k low = register k performs FunSel this edge.
- I  in  WIDTH  write data.
- OutASel  in  SELW  read select, port A.
- OutBSel  in  SELW  read select, port B.
- OutA  out  WIDTH  contents of register OutASel.
- OutB  out  WIDTH  contents of register OutBSel.
- ZeroA  out  1  high when OutA == 0.
- WrapFlags  out  NREGS  sticky per-register wrap flag.

Behaviour:
- Reset (async, Reset=1):
  - All registers and WrapFlags go to 0 immediately, regardless of Clock.
  - OutA/OutB = 0 and ZeroA = 1 while Reset is held.
  - Reset asserted mid-operation discards that edge's update.
- FunSel encodings, applied on rising Clock to each register k with RegSel[k]=0:
  - 000 DEC: Q-1 mod 2^WIDTH.
  - 001 INC: Q+1 mod 2^WIDTH.
  - 010 LOAD: Q=I.
  - 011 CLR: Q=0.
  - 100 LDL: Q[WIDTH/2-1:0]=I[WIDTH/2-1:0]; upper half held.
  - 101 LDH: Q[WIDTH-1:WIDTH/2]=I[WIDTH/2-1:0]; lower half held.
  - 110 SHL: Q={Q[WIDTH-2:0],1'b0}.
  - 111 HOLD: no change.
- Unselected registers (RegSel[k]=1) hold value and flag.
- Multiple RegSel bits low: all selected registers perform the same op in the same cycle; each uses its own current Q.
- RegSel all ones: nothing changes.
- WrapFlags[k]:
  - Set: INC from all-ones to 0, DEC from 0 to all-ones, or SHL shifting out a 1.
  - Cleared: LOAD, CLR, LDL or LDH on that register.
  - Otherwise held; set has priority only within the op that causes it.
- Reads: OutA/OutB are purely combinational from current register state, with no write bypass; a write is visible the cycle after the edge.
- Both ports may select the same register.
- A select value >= NREGS (NREGS not a power of two) returns 0 on that port.
- Latency: one edge for any write op; zero for reads.
- ZeroA is combinational on OutA.

Decomposition:
- Shared package:
  - FunSel encoding constants (FS_DEC, FS_INC, FS_LOAD, FS_CLR, FS_LDL, FS_LDH, FS_SHL, FS_HOLD).
  - clog2 helper function for SELW.
- One sub-module: param_reg_cell.
  - Contents: a single WIDTH-bit register plus its wrap flag.
  - Ports: Clock, Reset, En (active-high, driven by ~RegSel[k]), FunSel, I, Q, Wrap.
  - Top level generates NREGS cells plus two read muxes and the zero detect.

Test Plan:
- Reset: assert Reset between edges with regs nonzero -> all OutA/OutB read 0x00, WrapFlags=0, ZeroA=1 before the next Clock edge.
- Load/read: WIDTH=8, RegSel=4'b1110, FunSel=010, I=0x5A; then RegSel=4'b1101, I=0xC3 -> OutASel=0 gives 0x5A, OutBSel=1 gives 0xC3, regs 2/3 remain 0x00.
- Wrap: load R2=0xFF, then INC on R2 -> R2=0x00, WrapFlags[2]=1. Then DEC -> R2=0xFF, flag stays 1. Then LOAD 0x10 -> flag 0.
- Half loads: R3=0x00, LDH with I=0x0B, then LDL with I=0x07 -> R3=0xB7; upper input bits ignored.
- Multi-select/no bypass: R0=0x01, R1=0x80, RegSel=4'b1100, FunSel=110 -> OutA reads old values during the cycle. After the edge, R0=0x02, R1=0x00, WrapFlags[1]=1, ZeroA=1 when OutASel=1.
- Out-of-range select: NREGS=3, OutASel=2'b11 -> OutA=0x00, ZeroA=1. Reset asserted during an INC edge -> register ends at 0x00, not incremented.
